// File: rtl/target_driver.sv
// target_driver: picks each round's target box, drives its lamp and reports hit/wrong/miss.
// Optional feature: define TGT_NO_REPEAT_EN to forbid the same target in consecutive rounds.
module target_driver #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned WIN_D1      = 1000,
  parameter int unsigned WIN_D2      = 700,
  parameter int unsigned WIN_D3      = 400,
  parameter int unsigned FLASH_TICKS = 100,
  parameter int unsigned GAP_TICKS   = 250
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start_game,
  input  logic [1:0] difficulty_level,
  input  logic [2:0] lfsr_value,
  input  logic       sensor_valid,
  input  logic [2:0] sensor_box,
  output logic [7:0] gpio_out,
  output logic [2:0] target_box,
  output logic       target_valid,
  output logic       hit_pulse,
  output logic       wrong_pulse,
  output logic       miss_pulse,
  output logic [7:0] round_count
);

  typedef enum logic [2:0] {StIdle, StArm, StShow, StFlash, StGap} state_e;

  localparam logic [15:0] TickLast   = 16'(TICK_DIV - 1);
  localparam logic [15:0] WinD1      = 16'(WIN_D1);
  localparam logic [15:0] WinD2      = 16'(WIN_D2);
  localparam logic [15:0] WinD3      = 16'(WIN_D3);
  localparam logic [15:0] FlashTicks = 16'(FLASH_TICKS);
  localparam logic [15:0] GapTicks   = 16'(GAP_TICKS);

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] dur_q, dur_d;
  logic [15:0] win_q, win_d;
  logic [15:0] limit;
  logic [2:0]  target_q, target_d;
  logic [7:0]  gpio_q, gpio_d;
  logic [7:0]  round_q, round_d;
  logic        tvalid_q, tvalid_d;
  logic        hit_q, hit_d;
  logic        wrong_q, wrong_d;
  logic        miss_q, miss_d;
  logic        tick, done;
  logic        repeat_hit;

`ifdef TGT_NO_REPEAT_EN
  // Tracks whether target_q holds a target from a round since the last IDLE.
  logic prev_vld_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      prev_vld_q <= 1'b0;
    end else if (state_q == StIdle) begin
      prev_vld_q <= 1'b0;
    end else if (state_q == StArm) begin
      prev_vld_q <= 1'b1;
    end
  end

  assign repeat_hit = prev_vld_q && (lfsr_value == target_q);
`else
  assign repeat_hit = 1'b0;
`endif

  assign tick = (presc_q == TickLast);

  always_comb begin
    limit = 16'd1;
    case (state_q)
      StShow:  limit = win_q;
      StFlash: limit = FlashTicks;
      StGap:   limit = GapTicks;
      default: limit = 16'd1;
    endcase
  end

  assign done = tick && (dur_q == limit - 16'd1);

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    target_d = target_q;
    hit_d    = 1'b0;
    wrong_d  = 1'b0;
    miss_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_game) state_d = StArm;
      end
      StArm: begin
        target_d = repeat_hit ? lfsr_value + 3'd1 : lfsr_value;
        case (difficulty_level)
          2'd2:    win_d = WinD2;
          2'd3:    win_d = WinD3;
          default: win_d = WinD1;
        endcase
        state_d = StShow;
      end
      StShow: begin
        // A correct strike beats a simultaneous window expiry.
        if (sensor_valid && (sensor_box == target_q)) begin
          hit_d   = 1'b1;
          state_d = StFlash;
        end else begin
          wrong_d = sensor_valid;
          if (done) begin
            miss_d  = 1'b1;
            state_d = StGap;
          end
        end
      end
      StFlash: begin
        if (done) state_d = StGap;
      end
      StGap: begin
        if (done) state_d = StArm;
      end
      default: state_d = StIdle;
    endcase

    if (!start_game) begin
      state_d  = StIdle;
      win_d    = win_q;
      target_d = target_q;
      hit_d    = 1'b0;
      wrong_d  = 1'b0;
      miss_d   = 1'b0;
    end
  end

  // Both counters restart on every state change so each state is timed from its entry.
  always_comb begin
    presc_d = presc_q + 16'd1;
    dur_d   = dur_q;
    if (state_d != state_q) begin
      presc_d = 16'd0;
      dur_d   = 16'd0;
    end else if (tick) begin
      presc_d = 16'd0;
      dur_d   = dur_q + 16'd1;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    gpio_d = 8'h00;
    case (state_d)
      StShow:  gpio_d = 8'b1 << target_d;
      StFlash: gpio_d = 8'hFF;
      default: gpio_d = 8'h00;
    endcase
    tvalid_d = (state_d == StShow);
    round_d  = round_q + {7'd0, hit_d | miss_d};
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      presc_q  <= 16'd0;
      dur_q    <= 16'd0;
      win_q    <= WinD1;
      target_q <= 3'd0;
      gpio_q   <= 8'h00;
      tvalid_q <= 1'b0;
      hit_q    <= 1'b0;
      wrong_q  <= 1'b0;
      miss_q   <= 1'b0;
      round_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      dur_q    <= dur_d;
      win_q    <= win_d;
      target_q <= target_d;
      gpio_q   <= gpio_d;
      tvalid_q <= tvalid_d;
      hit_q    <= hit_d;
      wrong_q  <= wrong_d;
      miss_q   <= miss_d;
      round_q  <= round_d;
    end
  end

  assign gpio_out     = gpio_q;
  assign target_box   = target_q;
  assign target_valid = tvalid_q;
  assign hit_pulse    = hit_q;
  assign wrong_pulse  = wrong_q;
  assign miss_pulse   = miss_q;
  assign round_count  = round_q;

endmodule

// File: tb/tb_target_driver.sv
// Bench for target_driver: directed and randomized rounds checked against a round-level model.
module tb_target_driver;

  localparam int TD = 4;
  localparam int WD1 = 5;
  localparam int WD2 = 3;
  localparam int WD3 = 2;
  localparam int FL = 2;
  localparam int GP = 3;
`ifdef TGT_NO_REPEAT_EN
  localparam bit NoRep = 1'b1;
`else
  localparam bit NoRep = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       start_game;
  logic [1:0] difficulty_level;
  logic [2:0] lfsr_value;
  logic       sensor_valid;
  logic [2:0] sensor_box;
  logic [7:0] gpio_out;
  logic [2:0] target_box;
  logic       target_valid;
  logic       hit_pulse;
  logic       wrong_pulse;
  logic       miss_pulse;
  logic [7:0] round_count;

  int checks;
  int failures;
  int exp_rc;
  int prev_tgt;
  int tgt;

  target_driver #(
    .TICK_DIV   (TD),
    .WIN_D1     (WD1),
    .WIN_D2     (WD2),
    .WIN_D3     (WD3),
    .FLASH_TICKS(FL),
    .GAP_TICKS  (GP)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .start_game      (start_game),
    .difficulty_level(difficulty_level),
    .lfsr_value      (lfsr_value),
    .sensor_valid    (sensor_valid),
    .sensor_box      (sensor_box),
    .gpio_out        (gpio_out),
    .target_box      (target_box),
    .target_valid    (target_valid),
    .hit_pulse       (hit_pulse),
    .wrong_pulse     (wrong_pulse),
    .miss_pulse      (miss_pulse),
    .round_count     (round_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic int win_of(input int d);
    return (d == 3) ? WD3 : (d == 2) ? WD2 : WD1;
  endfunction

  function automatic int pick_target(input int lfsr);
    return (NoRep && prev_tgt == lfsr) ? (lfsr + 1) % 8 : lfsr;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_cyc(input string tag, input logic [7:0] g, input logic tv, input logic h,
                         input logic w, input logic m, input int t);
    chk({tag, ".gpio"}, gpio_out, g);
    chk({tag, ".tvalid"}, {7'd0, target_valid}, {7'd0, tv});
    chk({tag, ".hit"}, {7'd0, hit_pulse}, {7'd0, h});
    chk({tag, ".wrong"}, {7'd0, wrong_pulse}, {7'd0, w});
    chk({tag, ".miss"}, {7'd0, miss_pulse}, {7'd0, m});
    chk({tag, ".rounds"}, round_count, 8'(exp_rc));
    if (tv) chk({tag, ".target"}, {5'd0, target_box}, 8'(t));
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    sensor_valid = 1'b0;
  endtask

  task automatic noise();
    sensor_valid = 1'($urandom_range(0, 1));
    sensor_box   = 3'($urandom_range(0, 7));
  endtask

  // Entered in the ARM cycle; returns in the ARM cycle of the following round.
  task automatic do_round(input int diff, input int lfsr, input int hit_at, input int wrong_at,
                          input int wrong_off);
    int t;
    int show_len;
    bit hit;
    hit = 1'b0;
    difficulty_level = 2'(diff);
    lfsr_value = 3'(lfsr);
    t = pick_target(lfsr);
    prev_tgt = t;
    show_len = win_of(diff) * TD;
    exp_cyc("arm", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int c = 0; c < show_len && !hit; c++) begin
      step();
      lfsr_value = 3'($urandom_range(0, 7));
      difficulty_level = 2'($urandom_range(0, 3));
      exp_cyc("show", 8'(1 << t), 1'b1, 1'b0, (wrong_at >= 0 && c == wrong_at + 1), 1'b0, t);
      if (c == hit_at) begin
        sensor_valid = 1'b1;
        sensor_box = 3'(t);
        hit = 1'b1;
      end else if (c == wrong_at) begin
        sensor_valid = 1'b1;
        sensor_box = 3'((t + wrong_off) % 8);
      end
    end
    step();
    exp_rc = (exp_rc + 1) % 256;
    if (hit) begin
      for (int f = 0; f < FL * TD; f++) begin
        if (f > 0) step();
        exp_cyc("flash", 8'hFF, 1'b0, (f == 0), 1'b0, 1'b0, 0);
        noise();
      end
      step();
    end
    for (int g = 0; g < GP * TD; g++) begin
      if (g > 0) step();
      exp_cyc("gap", 8'h00, 1'b0, 1'b0, 1'b0, (!hit && g == 0), 0);
      noise();
    end
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_rc = 0;
    prev_tgt = -1;
    resetn = 1'b0;
    start_game = 1'b0;
    difficulty_level = 2'd0;
    lfsr_value = 3'd0;
    sensor_valid = 1'b0;
    sensor_box = 3'd0;
    #1;
    exp_cyc("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("reset.target", {5'd0, target_box}, 8'h00);

    start_game = 1'b1;
    repeat (3) step();
    exp_cyc("in_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    start_game = 1'b0;
    resetn = 1'b1;
    repeat (3) begin
      step();
      noise();
      exp_cyc("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end

    start_game = 1'b1;
    difficulty_level = 2'd1;
    lfsr_value = 3'd5;
    step();
    do_round(1, 5, -1, -1, 0);
    do_round(3, 2, 2, -1, 0);
    do_round(2, 1, -1, 3, 5);
    do_round(3, int'($urandom_range(0, 7)), WD3 * TD - 1, -1, 0);

    for (int r = 0; r < 6; r++) begin
      int d;
      int l;
      int sl;
      int ha;
      int wa;
      d = int'($urandom_range(0, 3));
      l = int'($urandom_range(0, 7));
      sl = win_of(d) * TD;
      ha = -1;
      wa = -1;
      if ($urandom_range(0, 1) == 1) ha = int'($urandom_range(0, sl - 1));
      if ($urandom_range(0, 1) == 1) wa = int'($urandom_range(0, sl - 2));
      if (ha >= 0 && wa >= ha) wa = -1;
      do_round(d, l, ha, wa, int'($urandom_range(1, 7)));
    end

    // Abort mid-SHOW, with a correct strike in the same cycle.
    difficulty_level = 2'd1;
    lfsr_value = 3'd3;
    tgt = pick_target(3);
    prev_tgt = tgt;
    exp_cyc("abort.arm", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step();
    exp_cyc("abort.show", 8'(1 << tgt), 1'b1, 1'b0, 1'b0, 1'b0, tgt);
    step();
    step();
    start_game = 1'b0;
    sensor_valid = 1'b1;
    sensor_box = 3'(tgt);
    step();
    exp_cyc("abort", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    prev_tgt = -1;
    repeat (4) begin
      step();
      exp_cyc("abort.idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      noise();
    end

    start_game = 1'b1;
    step();
    do_round(0, 7, -1, -1, 0);
    do_round(1, 7, 0, -1, 0);

    // Reset asserted mid-FLASH must clear everything without a clock edge.
    difficulty_level = 2'd2;
    lfsr_value = 3'd4;
    tgt = pick_target(4);
    prev_tgt = tgt;
    exp_cyc("rst.arm", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step();
    exp_cyc("rst.show", 8'(1 << tgt), 1'b1, 1'b0, 1'b0, 1'b0, tgt);
    sensor_valid = 1'b1;
    sensor_box = 3'(tgt);
    step();
    exp_rc = (exp_rc + 1) % 256;
    exp_cyc("rst.flash0", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    step();
    exp_cyc("rst.flash1", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    #2;
    resetn = 1'b0;
    #1;
    exp_rc = 0;
    exp_cyc("rst.async", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("rst.async.target", {5'd0, target_box}, 8'h00);
    step();
    exp_cyc("rst.held", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/target_driver.md
# target_driver

Transmit side of the mole-box interface: picks each round's target box from the LFSR value and drives that box's lamp on the GPIO header. It holds the lamp for a difficulty-dependent window and reports hit, wrong-box or miss per round to the game FSM. It sits between the LFSR and the GPIO output pins, and consumes the registered box reports from the sensor reader.

## Interface
Parameters:
- TICK_DIV, 50000: CLOCK_50 cycles per timing tick (1 ms).
- WIN_D1, 1000: show window in ticks, difficulty 1 (and 0).
- WIN_D2, 700: show window in ticks, difficulty 2.
- WIN_D3, 400: show window in ticks, difficulty 3.
- FLASH_TICKS, 100: hit-confirm flash length in ticks.
- GAP_TICKS, 250: blank interval between rounds in ticks.

Ports:
- CLOCK_50, in, 1: the single clock.
- resetn, in, 1: asynchronous, active-low reset.
- start_game, in, 1: level; high = rounds run, low = abort to IDLE.
- difficulty_level, in, 2: sampled at ARM.
- lfsr_value, in, 3: random box candidate, sampled at ARM.
- sensor_valid, in, 1: one-cycle strobe, a box was struck.
- sensor_box, in, 3: box index, valid with sensor_valid.
- gpio_out, out, 8: one-hot lamp drive, registered.
- target_box, out, 3: current target index.
- target_valid, out, 1: high in SHOW only.
- hit_pulse, out, 1: one cycle on correct hit.
- wrong_pulse, out, 1: one cycle on wrong-box strike in SHOW.
- miss_pulse, out, 1: one cycle on window expiry.
- round_count, out, 8: rounds completed (hit or miss), wraps 255→0.

## Operation
- States: IDLE, ARM, SHOW, FLASH, GAP.
- IDLE: all lamps off. start_game=1 → ARM.
- ARM: lasts one cycle.
  - Registers target_box from lfsr_value (repeat rule in Configuration).
  - Latches the window length: difficulty 0/1→WIN_D1, 2→WIN_D2, 3→WIN_D3.
  - Next state is SHOW.
- SHOW: gpio_out = 1<<target_box; target_valid=1.
  - sensor_valid with sensor_box==target_box → hit_pulse, go to FLASH.
  - sensor_valid with another box → wrong_pulse, stay in SHOW; the window is not restarted.
  - Window expiry → miss_pulse, go to GAP.
  - Hit and expiry in the same cycle: the hit wins; no miss_pulse.
- FLASH: gpio_out = 8'hFF for FLASH_TICKS, then GAP.
- GAP: gpio_out = 0 for GAP_TICKS, then ARM.
- round_count increments in the cycle hit_pulse or miss_pulse asserts.
- start_game=0 in any state: IDLE next cycle; lamps off; no pulses in that cycle; round_count kept.
- sensor_valid outside SHOW is ignored.
- Counters:
  - 16-bit prescaler produces one tick every TICK_DIV cycles.
  - 16-bit duration counter counts ticks.
  - Both clear on every state entry.

## Timing
- Reset values: gpio_out=0, target_box=0, target_valid=0, all pulses 0, round_count=0, state IDLE. Reset mid-round takes effect immediately and asynchronously.
- start_game rises in cycle t → ARM at t+1 → SHOW and lamp visible at t+2.
- A state of N ticks lasts exactly N×TICK_DIV cycles from entry.
- sensor_valid in cycle t during SHOW:
  - hit_pulse or wrong_pulse registered at t+1;
  - on a hit, FLASH lamps from t+1.
- The last SHOW cycle is still eligible for a hit.
- Pulses are registered and last exactly one cycle.
- ARM→SHOW→…→ARM turnaround on a miss: 1 + W×TICK_DIV + GAP_TICKS×TICK_DIV cycles, where W is the latched window in ticks.

## Configuration
- TGT_NO_REPEAT_EN defined:
  - if lfsr_value equals the previous round's target_box, the target is (lfsr_value+1) mod 8;
  - the first round after reset or IDLE has no previous target.
- Not defined: the target is lfsr_value unmodified; consecutive repeats are allowed.

## Test plan
All scenarios use TICK_DIV=4, WIN_D1=5, WIN_D2=3, WIN_D3=2, FLASH_TICKS=2, GAP_TICKS=3.
- Miss: difficulty 1, lfsr=5, start_game rises at t → gpio_out=8'h20 from t+2 for 20 cycles, miss_pulse at t+22, round_count=1, lamps off for 12 cycles, then ARM.
- Hit: difficulty 3, lfsr=2, sensor_valid with box 2 at the 3rd SHOW cycle → hit_pulse 1 cycle later, gpio_out=8'hFF for 8 cycles, then 0 for 12 cycles.
- Wrong box, then timeout: sensor_box=6 while target is 1 → wrong_pulse only, lamp stays on, miss_pulse at the original expiry.
- Simultaneous: correct strike in the final SHOW cycle → hit_pulse, no miss_pulse, round_count+1 once.
- Abort: start_game=0 mid-SHOW, then resetn=0 mid-FLASH.
  - After the abort: gpio_out=0 and IDLE next cycle, round_count kept.
  - After the reset: all outputs are at their reset values immediately.
- Repeat, with TGT_NO_REPEAT_EN defined: lfsr=7 for two rounds → targets 7 then 0.
- Repeat, without TGT_NO_REPEAT_EN: lfsr=7 for two rounds → targets 7 then 7.
